// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B/Z generator driven by relative move commands
// Optional QUAD_SKIP_INJECT_EN adds inject_skip for double-step (skipped state) injection.
module quad_encoder_gen #(
    parameter int WIDTH = 16,
    parameter int CPR   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_delta,
    input  logic [WIDTH-1:0] cmd_period,
    input  logic             stop,
`ifdef QUAD_SKIP_INJECT_EN
    input  logic             inject_skip,
`endif
    output logic             a,
    output logic             b,
    output logic             z,
    output logic [WIDTH-1:0] pos,
    output logic             busy,
    output logic             done
);
    localparam int             IW      = $clog2(CPR);
    localparam logic [IW-1:0]  IDX_MAX = IW'(CPR - 1);
    localparam logic [WIDTH:0] REM1    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] REM2    = {{(WIDTH-1){1'b0}}, 2'b10};

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;

    logic [1:0]       ph, ph_n;
    logic [IW-1:0]    idx, idx_1, idx_n;
    logic [WIDTH:0]   rem, mag;
    logic [WIDTH-1:0] period_r, timer, per_in, pos_n, stp;
    logic             dir, accept, tick, dbl, last, z_n;

    function automatic logic [IW-1:0] idx_step(input logic [IW-1:0] i, input logic fwd);
        if (fwd)
            return (i == IDX_MAX) ? '0 : i + 1'b1;
        else
            return (i == '0) ? IDX_MAX : i - 1'b1;
    endfunction

    // Magnitude needs one extra bit so the most negative delta is representable.
    always_comb begin
        mag    = cmd_delta[WIDTH-1] ? ({1'b0, ~cmd_delta} + 1'b1) : {1'b0, cmd_delta};
        per_in = (cmd_period == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cmd_period;
        accept = (state == IDLE) && cmd_valid;
        tick   = (state == RUN) && !stop && (timer == '0);
`ifdef QUAD_SKIP_INJECT_EN
        dbl    = tick && inject_skip && (rem > REM1);
`else
        dbl    = 1'b0;
`endif
        last   = tick && (dbl ? (rem == REM2) : (rem == REM1));
        stp    = {{(WIDTH-2){1'b0}}, dbl, ~dbl};
        ph_n   = dir ? (ph + {dbl, ~dbl}) : (ph - {dbl, ~dbl});
        pos_n  = dir ? (pos + stp) : (pos - stp);
        idx_1  = idx_step(idx, dir);
        idx_n  = dbl ? idx_step(idx_1, dir) : idx_1;
        // Index marks landing on, or a double step passing through, count zero.
        z_n    = (idx_n == '0) || (dbl && (idx_1 == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept && (mag != '0))
                    state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (stop || last)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 2'b00;
            a        <= 1'b0;
            b        <= 1'b0;
            z        <= 1'b0;
            pos      <= '0;
            idx      <= '0;
            rem      <= '0;
            dir      <= 1'b0;
            period_r <= '0;
            timer    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rem      <= mag;
                dir      <= ~cmd_delta[WIDTH-1];
                period_r <= per_in;
                timer    <= per_in - 1'b1;
                if (mag == '0)
                    done <= 1'b1;
            end else if (state == RUN) begin
                if (stop) begin
                    done <= 1'b1;
                end else if (timer == '0) begin
                    ph    <= ph_n;
                    a     <= ph_n[1];
                    b     <= ph_n[1] ^ ph_n[0];
                    pos   <= pos_n;
                    idx   <= idx_n;
                    z     <= z_n;
                    rem   <= rem - (dbl ? REM2 : REM1);
                    timer <= period_r - 1'b1;
                    if (last)
                        done <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - scoreboard bench for quad_encoder_gen (WIDTH=16, CPR=8)
module tb_quad_encoder_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_delta = '0;
    logic [15:0] cmd_period = '0;
    logic        stop = 1'b0;
    logic        inject_skip = 1'b0;
    logic        a, b, z, busy, done;
    logic [15:0] pos;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        a;
        logic        b;
        logic        z;
        logic [15:0] pos;
        logic        done;
    } ev_t;
    ev_t sb[$];

    quad_encoder_gen #(.WIDTH(16), .CPR(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_delta  (cmd_delta),
        .cmd_period (cmd_period),
        .stop       (stop),
`ifdef QUAD_SKIP_INJECT_EN
        .inject_skip(inject_skip),
`endif
        .a          (a),
        .b          (b),
        .z          (z),
        .pos        (pos),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic [1:0] ab, input logic zz,
                             input logic [15:0] p, input logic d);
        ev_t e;
        e.cyc = c; e.a = ab[1]; e.b = ab[0]; e.z = zz; e.pos = p; e.done = d;
        sb.push_back(e);
    endtask

    // Monitor: every visible output change or done pulse must match the head of the scoreboard.
    initial begin
        logic [18:0] prev;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = {a, b, z, pos};
            end else if (({a, b, z, pos} != prev) || done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'({a, b, z, pos, done}), 32'hFFFFFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ev_ab", 32'({a, b}), 32'({e.a, e.b}));
                    chk("ev_z", 32'(z), 32'(e.z));
                    chk("ev_pos", 32'(pos), 32'(e.pos));
                    chk("ev_done", 32'(done), 32'(e.done));
                end
                prev = {a, b, z, pos};
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic at_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] p, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 32'(n), 32'd0);
        #1;
        cmd_valid = 1'b1; cmd_delta = d; cmd_period = p;
        acc = cyc + 1;
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        logic [1:0] abt [4];
        abt[0] = 2'b00; abt[1] = 2'b01; abt[2] = 2'b11; abt[3] = 2'b10;

        repeat (2) @(negedge clk);
        chk("rst_ab", 32'({a, b}), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        #2 rst_n = 1'b1;

        // +4 steps every 3 clocks
        send(16'd4, 16'd3, acc);
        expect_ev(acc + 3, 2'b01, 1'b0, 16'd1, 1'b0);
        expect_ev(acc + 6, 2'b11, 1'b0, 16'd2, 1'b0);
        expect_ev(acc + 9, 2'b10, 1'b0, 16'd3, 1'b0);
        expect_ev(acc + 12, 2'b00, 1'b0, 16'd4, 1'b1);
        at_cyc(acc);
        chk("t1_ready_busy", 32'(cmd_ready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        at_cyc(acc + 13);
        chk("t1_ready_after", 32'(cmd_ready), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        drain("t1_drain");

        // -2 steps at period 1 from zero: wraps pos, no index
        do_reset();
        send(16'hFFFE, 16'd1, acc);
        expect_ev(acc + 1, 2'b10, 1'b0, 16'hFFFF, 1'b0);
        expect_ev(acc + 2, 2'b11, 1'b0, 16'hFFFE, 1'b1);
        drain("t2_drain");

        // +9 steps with CPR=8: index set by 8th step, cleared by 9th
        do_reset();
        send(16'd9, 16'd1, acc);
        for (int k = 1; k <= 9; k++)
            expect_ev(acc + k, abt[2'(k % 4)], (k == 8), 16'(k), (k == 9));
        drain("t3_drain");

        // +100 at period 2, stop after 10th step; a mid-move command is ignored
        do_reset();
        send(16'd100, 16'd2, acc);
        for (int k = 1; k <= 10; k++)
            expect_ev(acc + 2 * k, abt[2'(k % 4)], (k == 8), 16'(k), 1'b0);
        expect_ev(acc + 21, 2'b11, 1'b0, 16'd10, 1'b1);
        at_cyc(acc + 5);
        #1 cmd_valid = 1'b1; cmd_delta = 16'd5; cmd_period = 16'd1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        at_cyc(acc + 20);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        at_cyc(acc + 30);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_pos", 32'(pos), 32'd10);
        drain("t4_drain");

        // delta 0: done only, ready stays high
        send(16'd0, 16'd4, acc);
        expect_ev(acc, 2'b11, 1'b0, 16'd10, 1'b1);
        at_cyc(acc);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        at_cyc(acc + 2);
        chk("t5_ready_later", 32'(cmd_ready), 32'd1);
        drain("t5_drain");

        // period 0 behaves as 1
        send(16'd3, 16'd0, acc);
        expect_ev(acc + 1, 2'b10, 1'b0, 16'd11, 1'b0);
        expect_ev(acc + 2, 2'b00, 1'b0, 16'd12, 1'b0);
        expect_ev(acc + 3, 2'b01, 1'b0, 16'd13, 1'b1);
        drain("t6_drain");

        // async reset mid-move discards the rest of the move
        do_reset();
        send(16'd5, 16'd2, acc);
        expect_ev(acc + 2, 2'b01, 1'b0, 16'd1, 1'b0);
        expect_ev(acc + 4, 2'b11, 1'b0, 16'd2, 1'b0);
        expect_ev(acc + 6, 2'b10, 1'b0, 16'd3, 1'b0);
        at_cyc(acc + 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pos", 32'(pos), 32'd0);
        chk("arst_ab", 32'({a, b}), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk); #2 rst_n = 1'b1;
        at_cyc(acc + 20);
        chk("arst_pos_after", 32'(pos), 32'd0);
        chk("arst_queue", 32'(sb.size()), 32'd0);

`ifdef QUAD_SKIP_INJECT_EN
        // double step on the first edge: 00 -> 11 directly
        do_reset();
        inject_skip = 1'b1;
        send(16'd4, 16'd1, acc);
        @(posedge clk); #1 inject_skip = 1'b0;
        expect_ev(acc + 1, 2'b11, 1'b0, 16'd2, 1'b0);
        expect_ev(acc + 2, 2'b10, 1'b0, 16'd3, 1'b0);
        expect_ev(acc + 3, 2'b00, 1'b0, 16'd4, 1'b1);
        drain("skip_drain");
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
